// File: rtl/display_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_pkg
// Shared constants and helpers for the 4-digit HH:MM display scan controller.
//   - Digit index constants (scan order: minute ones first, hour tens last).
//   - ANODES_OFF: all common-anode selects released (active-low).
//   - anode_sel():  one-hot-low anode pattern for a digit index.
//   - digit_sel():  picks the BCD nibble for a digit index out of a snapshot.
// -----------------------------------------------------------------------------
package display_scan_ctrl_pkg;

   localparam logic [1:0] DIG_MIN_ONES = 2'd0;
   localparam logic [1:0] DIG_MIN_TENS = 2'd1;
   localparam logic [1:0] DIG_HR_ONES  = 2'd2;
   localparam logic [1:0] DIG_HR_TENS  = 2'd3;

   localparam logic [3:0] ANODES_OFF   = 4'b1111;

   function automatic logic [3:0] anode_sel(input logic [1:0] idx);
      logic [3:0] w_onehot;
      w_onehot = 4'b0001 << idx;
      return ~w_onehot;
   endfunction

   function automatic logic [3:0] digit_sel(input logic [15:0] snap, input logic [1:0] idx);
      logic [3:0] w_nib;
      w_nib = 4'd0;
      unique case (idx)
         DIG_MIN_ONES: w_nib = snap[3:0];
         DIG_MIN_TENS: w_nib = snap[7:4];
         DIG_HR_ONES:  w_nib = snap[11:8];
         DIG_HR_TENS:  w_nib = snap[15:12];
         default:      w_nib = 4'd0;
      endcase
      return w_nib;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Modulo-MODULUS counter advanced by i_en, with synchronous active-low reset.
// Used both as the per-slot refresh divider and as the frame-to-blink divider.
// Ports:
//   i_clk       system clock
//   i_rst_n     synchronous active-low reset (count -> 0)
//   i_en        advance the count this cycle
//   o_tick      i_en at terminal count (MODULUS-1): the counter wraps this edge
//   o_in_guard  count is within 0..GUARD-1 (never set when GUARD == 0)
// -----------------------------------------------------------------------------
module scan_prescaler #(
   parameter int unsigned MODULUS = 4,
   parameter int unsigned GUARD   = 0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_tick,
   output logic o_in_guard
);

   localparam int unsigned W = (MODULUS > 1) ? $clog2(MODULUS) : 1;
   localparam logic [W-1:0] LAST       = W'(MODULUS - 1);
   localparam logic [W-1:0] GUARD_LAST = W'((GUARD > 0) ? GUARD - 1 : 0);

   logic [W-1:0] r_count;
   logic         w_at_last;

   assign w_at_last = (r_count == LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= w_at_last ? '0 : r_count + 1'b1;
      end
   end

   assign o_tick     = i_en && w_at_last;
   assign o_in_guard = (GUARD > 0) && (r_count <= GUARD_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed scan controller for a 4-digit HH:MM common-anode display,
// feeding a BCD-to-7-segment decoder. One digit per slot; every slot opens
// with GUARD cycles of all anodes off to stop ghosting.
// Ports:
//   i_clk          system clock
//   i_rst_n        synchronous active-low reset
//   i_digits       BCD {hour tens, hour ones, min tens, min ones}
//   i_blank        1 = whole display dark (scan keeps running)
//   i_lzb          1 = suppress hour-tens digit when it is 0
//   i_blink_mask   per-digit blink enable, bit i = digit index i
//   i_colon_en     1 = colon lit
//   i_colon_blink  1 = colon follows the blink phase
//   o_digit_out    BCD nibble to the decoder (non-BCD passed through)
//   o_seg_en       decoder enable
//   o_an           active-low anode selects, bit i = digit index i
//   o_dp_n         active-low colon
// All outputs are registered from the current counter state, so pins lag the
// counters by exactly one cycle.
// -----------------------------------------------------------------------------
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned GUARD        = 2,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_digits,
   input  logic        i_blank,
   input  logic        i_lzb,
   input  logic [3:0]  i_blink_mask,
   input  logic        i_colon_en,
   input  logic        i_colon_blink,
   output logic [3:0]  o_digit_out,
   output logic        o_seg_en,
   output logic [3:0]  o_an,
   output logic        o_dp_n
);

   // Scan state
   logic [1:0]  r_idx;
   logic [15:0] r_snap;
   logic        r_first;        // first cycle out of reset: snapshot not yet loaded
   logic        r_blink_phase;  // 1 = "off" half of the blink period

   // Registered outputs
   logic [3:0]  r_digit_out;
   logic        r_seg_en;
   logic [3:0]  r_an;
   logic        r_dp_n;

   logic        w_slot_tick;
   logic        w_in_guard;
   logic        w_frame_end;
   logic        w_blink_wrap;
   logic [15:0] w_snap;
   logic        w_lz_kill;
   logic        w_blink_kill;
   logic        w_colon_on;
   logic [3:0]  w_digit;
   logic        w_seg_en;
   logic [3:0]  w_an;
   logic        w_dp_n;

   scan_prescaler #(
      .MODULUS (REFRESH_DIV),
      .GUARD   (GUARD)
   ) u_slot_div (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (1'b1),
      .o_tick     (w_slot_tick),
      .o_in_guard (w_in_guard)
   );

   assign w_frame_end = w_slot_tick && (r_idx == DIG_HR_TENS);

   scan_prescaler #(
      .MODULUS (BLINK_FRAMES),
      .GUARD   (0)
   ) u_blink_div (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (w_frame_end),
      .o_tick     (w_blink_wrap),
      .o_in_guard ()
   );

   // On the very first cycle after reset the snapshot register still holds 0,
   // so bypass to the live digits; that is the value being captured this edge.
   assign w_snap = r_first ? i_digits : r_snap;

   always_comb begin
      w_digit      = digit_sel(w_snap, r_idx);
      w_lz_kill    = i_lzb && (r_idx == DIG_HR_TENS) && (w_snap[15:12] == 4'd0);
      w_blink_kill = i_blink_mask[r_idx] && r_blink_phase;
      w_seg_en     = !w_in_guard && !i_blank && !w_blink_kill && !w_lz_kill;
      w_an         = w_in_guard ? ANODES_OFF : anode_sel(r_idx);
      w_colon_on   = !w_in_guard && (r_idx == DIG_HR_ONES) && i_colon_en &&
                     !(i_colon_blink && r_blink_phase) && !i_blank;
      w_dp_n       = !w_colon_on;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_idx         <= DIG_MIN_ONES;
         r_snap        <= 16'h0000;
         r_first       <= 1'b1;
         r_blink_phase <= 1'b0;
         r_digit_out   <= 4'd0;
         r_seg_en      <= 1'b0;
         r_an          <= ANODES_OFF;
         r_dp_n        <= 1'b1;
      end else begin
         r_first <= 1'b0;
         if (w_slot_tick) begin
            r_idx <= r_idx + 2'd1;
         end
         if (w_frame_end || r_first) begin
            r_snap <= i_digits;
         end
         // Toggles on the frame-end edge, so the new phase covers the next
         // frame from its first slot onward.
         if (w_blink_wrap) begin
            r_blink_phase <= ~r_blink_phase;
         end
         r_digit_out <= w_digit;
         r_seg_en    <= w_seg_en;
         r_an        <= w_an;
         r_dp_n      <= w_dp_n;
      end
   end

   assign o_digit_out = r_digit_out;
   assign o_seg_en    = r_seg_en;
   assign o_an        = r_an;
   assign o_dp_n      = r_dp_n;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Directed bench for display_scan_ctrl with REFRESH_DIV=4, GUARD=1,
// BLINK_FRAMES=2: each slot is one guard cycle plus three active cycles.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

   logic        clk;
   logic        rst_n;
   logic [15:0] digits;
   logic        blank;
   logic        lzb;
   logic [3:0]  blink_mask;
   logic        colon_en;
   logic        colon_blink;
   logic [3:0]  digit_out;
   logic        seg_en;
   logic [3:0]  an;
   logic        dp_n;

   int n_total;
   int n_bad;

   display_scan_ctrl #(
      .REFRESH_DIV  (4),
      .GUARD        (1),
      .BLINK_FRAMES (2)
   ) u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_digits      (digits),
      .i_blank       (blank),
      .i_lzb         (lzb),
      .i_blink_mask  (blink_mask),
      .i_colon_en    (colon_en),
      .i_colon_blink (colon_blink),
      .o_digit_out   (digit_out),
      .o_seg_en      (seg_en),
      .o_an          (an),
      .o_dp_n        (dp_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Hold reset for n cycles, check the reset outputs, release.
   task automatic do_reset(input int n, input logic [15:0] dig);
      rst_n  = 1'b0;
      digits = dig;
      repeat (n) @(negedge clk);
      check("rst_an",    {12'd0, an},        16'h000f);
      check("rst_seg",   {15'd0, seg_en},    16'h0000);
      check("rst_dp",    {15'd0, dp_n},      16'h0001);
      check("rst_digit", {12'd0, digit_out}, 16'h0000);
      rst_n = 1'b1;
   endtask

   // One full slot: guard cycle (anodes off, digit already valid) + 3 active.
   task automatic slot(input logic [3:0] an_e, input logic [3:0] dig_e,
                       input logic seg_e, input logic dp_e);
      @(negedge clk);
      check("guard_an",    {12'd0, an},        16'h000f);
      check("guard_seg",   {15'd0, seg_en},    16'h0000);
      check("guard_digit", {12'd0, digit_out}, {12'd0, dig_e});
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("act_an",    {12'd0, an},        {12'd0, an_e});
         check("act_digit", {12'd0, digit_out}, {12'd0, dig_e});
         check("act_seg",   {15'd0, seg_en},    {15'd0, seg_e});
         check("act_dp",    {15'd0, dp_n},      {15'd0, dp_e});
      end
   endtask

   // Frame of digits 1234 with blink_mask=1100 and a blinking colon.
   task automatic blink_frame(input logic off);
      slot(4'b1110, 4'd4, 1'b1, 1'b1);
      slot(4'b1101, 4'd3, 1'b1, 1'b1);
      slot(4'b1011, 4'd2, ~off, off);
      slot(4'b0111, 4'd1, ~off, 1'b1);
   endtask

   initial begin
      n_total     = 0;
      n_bad       = 0;
      blank       = 1'b0;
      lzb         = 1'b0;
      blink_mask  = 4'b0000;
      colon_en    = 1'b0;
      colon_blink = 1'b0;

      // Reset, scan order and snapshot: digits change while idx1 is scanning.
      do_reset(3, 16'h1234);
      slot(4'b1110, 4'd4, 1'b1, 1'b1);
      digits = 16'h5678;
      slot(4'b1101, 4'd3, 1'b1, 1'b1);
      slot(4'b1011, 4'd2, 1'b1, 1'b1);
      slot(4'b0111, 4'd1, 1'b1, 1'b1);
      slot(4'b1110, 4'd8, 1'b1, 1'b1);
      slot(4'b1101, 4'd7, 1'b1, 1'b1);
      slot(4'b1011, 4'd6, 1'b1, 1'b1);
      slot(4'b0111, 4'd5, 1'b1, 1'b1);

      // Leading-zero blanking, then lzb released (live control).
      lzb = 1'b1;
      do_reset(1, 16'h0905);
      slot(4'b1110, 4'd5, 1'b1, 1'b1);
      slot(4'b1101, 4'd0, 1'b1, 1'b1);
      slot(4'b1011, 4'd9, 1'b1, 1'b1);
      slot(4'b0111, 4'd0, 1'b0, 1'b1);
      lzb = 1'b0;
      slot(4'b1110, 4'd5, 1'b1, 1'b1);
      slot(4'b1101, 4'd0, 1'b1, 1'b1);
      slot(4'b1011, 4'd9, 1'b1, 1'b1);
      slot(4'b0111, 4'd0, 1'b1, 1'b1);

      // Blink: two frames visible, two frames off, then visible again.
      blink_mask  = 4'b1100;
      colon_en    = 1'b1;
      colon_blink = 1'b1;
      do_reset(1, 16'h1234);
      blink_frame(1'b0);
      blink_frame(1'b0);
      blink_frame(1'b1);
      blink_frame(1'b1);
      blink_frame(1'b0);
      blink_mask  = 4'b0000;
      colon_blink = 1'b0;

      // Blank mid-slot, then a one-cycle reset pulse during idx2.
      do_reset(1, 16'h1234);
      @(negedge clk);
      check("bl_guard_an", {12'd0, an}, 16'h000f);
      @(negedge clk);
      check("bl_pre_seg", {15'd0, seg_en}, 16'h0001);
      blank = 1'b1;
      @(negedge clk);
      check("bl_an",  {12'd0, an},     16'h000e);
      check("bl_seg", {15'd0, seg_en}, 16'h0000);
      check("bl_dp",  {15'd0, dp_n},   16'h0001);
      @(negedge clk);
      check("bl_seg2", {15'd0, seg_en}, 16'h0000);
      slot(4'b1101, 4'd3, 1'b0, 1'b1);
      @(negedge clk);
      check("bl_i2_guard", {12'd0, an}, 16'h000f);
      @(negedge clk);
      check("bl_i2_an", {12'd0, an},   16'h000b);
      check("bl_i2_dp", {15'd0, dp_n}, 16'h0001);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_an",    {12'd0, an},        16'h000f);
      check("mid_rst_seg",   {15'd0, seg_en},    16'h0000);
      check("mid_rst_digit", {12'd0, digit_out}, 16'h0000);
      check("mid_rst_dp",    {15'd0, dp_n},      16'h0001);
      rst_n    = 1'b1;
      blank    = 1'b0;
      colon_en = 1'b0;
      slot(4'b1110, 4'd4, 1'b1, 1'b1);
      slot(4'b1101, 4'd3, 1'b1, 1'b1);

      // Non-BCD nibble passes straight through.
      do_reset(1, 16'h123c);
      slot(4'b1110, 4'hc, 1'b1, 1'b1);
      slot(4'b1101, 4'd3, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
